// File: rtl/pcileech_ft601_tx_sched_pkg.sv
// Shared types and constants for the FT601 upstream scheduler.
//   MAGIC_DEF   : default value of tag dword bits [31:28]
//   TAG_EMPTY   : tag nibble of an unfilled frame slot
//   FRAME_SLOTS : data dwords per 256-bit frame
//   tag_nib_t   : per-slot tag nibble {last, src id}
package pcileech_tx_pkg;
  localparam logic [3:0] MAGIC_DEF   = 4'hE;
  localparam logic [3:0] TAG_EMPTY   = 4'hF;
  localparam int         FRAME_SLOTS = 7;

  typedef struct packed {
    logic       last;
    logic [2:0] src;
  } tag_nib_t;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER} sched_state_t;
endpackage

// File: rtl/pcileech_ft601_tx_sched_if.sv
// Source/sink bundle of the FT601 upstream scheduler.
//   src_data/src_last/src_valid/src_ready : NUM_SRC dword streams (source i at index i)
//   out_afull                             : downstream FIFO almost full
//   out_data/out_valid                    : 256-bit frame write strobe
//   busy                                  : activity indication
// master = stream producers + downstream FIFO side, slave = scheduler.
interface pcileech_ft601_tx_sched_if #(parameter int NUM_SRC = 3);
  logic [NUM_SRC-1:0][31:0] src_data;
  logic [NUM_SRC-1:0]       src_last;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     out_afull;
  logic [255:0]             out_data;
  logic                     out_valid;
  logic                     busy;

  modport master (output src_data, src_last, src_valid, out_afull,
                  input  src_ready, out_data, out_valid, busy);
  modport slave  (input  src_data, src_last, src_valid, out_afull,
                  output src_ready, out_data, out_valid, busy);
endinterface

// File: rtl/pcileech_ft601_tx_sched_arb.sv
// Round-robin pick: first requester at or after i_ptr, wrapping NUM_SRC-1 -> 0.
//   i_req     : request vector
//   i_ptr     : search start (always < NUM_SRC)
//   o_gnt_idx : encoded winner
//   o_gnt_any : some requester was found
module pcileech_rr_arb #(
  parameter int NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [2:0]         i_ptr,
  output logic [2:0]         o_gnt_idx,
  output logic               o_gnt_any
);
  logic [3:0] w_idx;

  always_comb begin
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    w_idx     = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      // ptr+off < 2*NUM_SRC, so one subtraction wraps it
      w_idx = {1'b0, i_ptr} + 4'(off);
      if (w_idx >= 4'(NUM_SRC)) w_idx = w_idx - 4'(NUM_SRC);
      for (int j = 0; j < NUM_SRC; j++)
        if (!o_gnt_any && (w_idx == 4'(j)) && i_req[j]) begin
          o_gnt_any = 1'b1;
          o_gnt_idx = 3'(j);
        end
    end
  end
endmodule

// File: rtl/pcileech_ft601_tx_sched.sv
// FT601 upstream scheduler: per-packet round-robin over NUM_SRC dword streams,
// packing accepted dwords into 256-bit frames (tag dword + 7 data dwords).
// Partial frames are flushed after TIMEOUT_CYC cycles without an accept.
//   clk : FT601 clock
//   rst : synchronous, active-high reset
//   bus : slave side of the source/sink bundle
module pcileech_ft601_tx_sched
  import pcileech_tx_pkg::*;
#(
  parameter int         NUM_SRC     = 3,
  parameter int         TIMEOUT_CYC = 64,
  parameter logic [3:0] MAGIC       = MAGIC_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  pcileech_ft601_tx_sched_if.slave     bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  // timer holds the idle cycles already elapsed; the flush decision is taken in
  // the idle cycle that makes out_valid land TIMEOUT_CYC cycles after the last accept
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 2);
  localparam logic [4*FRAME_SLOTS-1:0] EMPTY_TAGS = {FRAME_SLOTS{TAG_EMPTY}};

  sched_state_t                    r_state, w_state_nxt;
  logic [2:0]                      r_grant, r_rr, r_slot;
  tag_nib_t [FRAME_SLOTS-1:0]      r_tags, w_tags;
  logic [FRAME_SLOTS-1:0][31:0]    r_data, w_data;
  logic [TW-1:0]                   r_timer;
  logic [255:0]                    r_out_data;
  logic                            r_out_valid;

  logic [2:0]  w_arb_idx;
  logic        w_arb_any;
  logic        w_sel_valid, w_sel_last, w_acc, w_full, w_to, w_emit;
  logic [31:0] w_sel_data;

  pcileech_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
    .i_req     (bus.src_valid),
    .i_ptr     (r_rr),
    .o_gnt_idx (w_arb_idx),
    .o_gnt_any (w_arb_any)
  );

  // mux of the granted source
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (r_grant == 3'(i)) begin
        w_sel_valid = bus.src_valid[i];
        w_sel_last  = bus.src_last[i];
        w_sel_data  = bus.src_data[i];
      end
  end

  assign w_acc = (r_state == S_XFER) && w_sel_valid && !bus.out_afull;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++)
      bus.src_ready[i] = w_acc && (r_grant == 3'(i));
  end

  // frame contents after merging this cycle's accept
  always_comb begin
    w_tags = r_tags;
    w_data = r_data;
    if (w_acc)
      for (int k = 0; k < FRAME_SLOTS; k++)
        if (r_slot == 3'(k)) begin
          w_tags[k] = '{last: w_sel_last, src: r_grant};
          w_data[k] = w_sel_data;
        end
  end

  assign w_full = w_acc && (r_slot == 3'(FRAME_SLOTS - 1));
  assign w_to   = !w_acc && (r_slot != 3'd0) && (r_timer == TO_LAST);
  assign w_emit = w_full || w_to;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (|bus.src_valid) w_state_nxt = S_ARB;
      // requesters never drop before their first accept, so w_arb_any is
      // normally set; fall back to IDLE rather than grant nobody
      S_ARB:   w_state_nxt = w_arb_any ? S_XFER : S_IDLE;
      S_XFER:  if (w_acc && w_sel_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr        <= '0;
      r_slot      <= '0;
      r_tags      <= EMPTY_TAGS;
      r_data      <= '0;
      r_timer     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_emit;
      if (r_state == S_ARB && w_arb_any) begin
        r_grant <= w_arb_idx;
        r_rr    <= (w_arb_idx == 3'(NUM_SRC - 1)) ? 3'd0 : w_arb_idx + 3'd1;
      end
      if (w_emit) begin
        r_out_data <= {w_data, MAGIC, w_tags};
        r_tags     <= EMPTY_TAGS;
        r_data     <= '0;
        r_slot     <= '0;
      end else begin
        r_tags <= w_tags;
        r_data <= w_data;
        if (w_acc) r_slot <= r_slot + 3'd1;
      end
      if (w_acc || w_emit || r_slot == 3'd0) r_timer <= '0;
      else                                   r_timer <= r_timer + TW'(1);
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_slot != 3'd0) || (r_state != S_IDLE);
endmodule

// File: tb/tb_pcileech_ft601_tx_sched.sv
module tb_pcileech_ft601_tx_sched;
  localparam int         NS = 3;
  localparam int         TO = 16;
  localparam logic [3:0] MG = 4'hE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcileech_ft601_tx_sched_if #(.NUM_SRC(NS)) ifc();
  pcileech_ft601_tx_sched #(.NUM_SRC(NS), .TIMEOUT_CYC(TO), .MAGIC(MG)) dut (
    .clk(clk), .rst(rst), .bus(ifc));

  int n_chk = 0, n_fail = 0, cyc = 0;

  // stimulus: per-source dword queues, bit 32 = last
  logic [32:0] src_q [NS][$];
  bit          started [NS];
  bit          drop_en = 0, afull_force = 0;
  int          afull_pct = 0;

  // reference model: packet owner, rr pointer, open frame as lists
  int          m_phase = 0, m_owner = 0, m_rr = 0, m_last_acc = 0;
  logic [31:0] m_fd[$];
  logic [3:0]  m_fn[$];
  logic        m_ov = 0;
  logic [255:0] m_od = '0;
  int          grant_log[$];

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    logic [32:0] h;
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        ifc.src_data[i]  = h[31:0];
        ifc.src_last[i]  = h[32];
        ifc.src_valid[i] = !(drop_en && started[i] && $urandom_range(3) == 0);
      end else begin
        ifc.src_data[i]  = $urandom;
        ifc.src_last[i]  = 1'b0;
        ifc.src_valid[i] = 1'b0;
      end
    end
    ifc.out_afull = afull_force || (int'($urandom_range(99)) < afull_pct);
  endtask

  task automatic load(int s, int n, logic [31:0] base);
    for (int k = 0; k < n; k++) src_q[s].push_back({k == n - 1, base + 32'(k)});
  endtask

  function automatic logic [255:0] build();
    logic [255:0] f;
    f = '0;
    f[31:0] = {MG, 28'hFFFFFFF};
    for (int k = 0; k < m_fd.size(); k++) begin
      f[4*k +: 4]      = m_fn[k];
      f[32*(k+1) +: 32] = m_fd[k];
    end
    return f;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rr = 0; m_owner = 0; m_ov = 0; m_od = '0;
    m_fd.delete(); m_fn.delete();
  endtask

  // one clock: compare at negedge, advance model, drive next inputs after posedge
  task automatic step();
    logic [NS-1:0] er;
    bit acc, emit;
    @(negedge clk);
    er = '0; acc = 0; emit = 0;
    if (m_phase == 2 && ifc.src_valid[m_owner] && !ifc.out_afull) begin
      acc = 1; er[m_owner] = 1'b1;
    end
    chk("src_ready", ifc.src_ready, er);
    chk("out_valid", ifc.out_valid, m_ov);
    if (m_ov) chk("out_data", ifc.out_data, m_od);
    chk("busy", ifc.busy, (m_fd.size() != 0 || m_phase != 0));
    if (acc) begin
      m_fd.push_back(ifc.src_data[m_owner]);
      m_fn.push_back({ifc.src_last[m_owner], 3'(m_owner)});
      m_last_acc = cyc;
      emit = (m_fd.size() == 7);
      void'(src_q[m_owner].pop_front());
      started[m_owner] = !ifc.src_last[m_owner];
    end else begin
      emit = (m_fd.size() > 0 && cyc - m_last_acc == TO - 1);
    end
    m_ov = emit;
    if (emit) begin
      m_od = build(); m_fd.delete(); m_fn.delete();
    end
    case (m_phase)
      0: if (|ifc.src_valid) m_phase = 1;
      1: begin
        m_phase = 0;
        for (int off = 0; off < NS; off++)
          if (m_phase == 0 && ifc.src_valid[(m_rr + off) % NS]) begin
            m_owner = (m_rr + off) % NS;
            m_rr    = (m_owner + 1) % NS;
            m_phase = 2;
            grant_log.push_back(m_owner);
          end
      end
      2: if (acc && ifc.src_last[m_owner]) m_phase = 0;
      default: m_phase = 0;
    endcase
    cyc++;
    @(posedge clk); #1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NS; i++) begin src_q[i].delete(); started[i] = 0; end
    drive();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc++;
    model_reset();
    drive();
  endtask

  task automatic chk_zero(string t);
    chk({t, "_rdy"},  ifc.src_ready, 0);
    chk({t, "_ov"},   ifc.out_valid, 0);
    chk({t, "_od"},   ifc.out_data, 0);
    chk({t, "_busy"}, ifc.busy, 0);
  endtask

  initial begin
    logic [23:0] ord;
    ifc.src_data = '0; ifc.src_last = '0; ifc.src_valid = '0; ifc.out_afull = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_zero("reset");

    // single 7-dword packet from src0: frame after IDLE+ARB+7 accepts
    load(0, 7, 32'h1); drive();
    repeat (9) step();
    chk("t1_ov",  ifc.out_valid, 1);
    chk("t1_tag", ifc.out_data[31:0], 32'hE8000000);
    chk("t1_d1",  ifc.out_data[63:32], 32'h1);
    chk("t1_d7",  ifc.out_data[255:224], 32'h7);
    repeat (3) step();

    // src0 and src2 alternating 2-dword packets
    do_reset(); grant_log.delete();
    for (int r = 0; r < 3; r++) begin
      load(0, 2, 32'h100 + 32'(r * 16));
      load(2, 2, 32'h200 + 32'(r * 16));
    end
    drive();
    repeat (50) step();
    ord = '0;
    foreach (grant_log[k]) ord = {ord[19:0], 4'(grant_log[k])};
    chk("t2_ngrant", grant_log.size(), 6);
    chk("t2_order", ord, 24'h020202);

    // 3 dwords then idle: padded flush TO cycles after last accept
    do_reset();
    load(1, 3, 32'hA1); drive();
    repeat (TO + 3) step();
    chk("t3_early", ifc.out_valid, 0);
    step();
    chk("t3_ov",  ifc.out_valid, 1);
    chk("t3_tag", ifc.out_data[31:0], 32'hEFFFF911);
    chk("t3_d3",  ifc.out_data[127:96], 32'hA3);
    chk("t3_pad", ifc.out_data[255:128], 0);

    // 20-cycle almost-full stall mid-packet
    do_reset();
    load(2, 10, 32'h300); drive();
    repeat (4) step();
    afull_force = 1; drive();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t4_rdy", ifc.src_ready, 0);
    end
    afull_force = 0; drive();
    repeat (40) step();

    // reset after 4 accepted dwords, then a clean packet
    do_reset();
    load(0, 10, 32'h400); drive();
    repeat (6) step();
    do_reset();
    chk_zero("t5_rst");
    load(0, 7, 32'h51); drive();
    repeat (9) step();
    chk("t5_ov",  ifc.out_valid, 1);
    chk("t5_tag", ifc.out_data[31:0], 32'hE8000000);
    chk("t5_d1",  ifc.out_data[63:32], 32'h51);
    repeat (3) step();

    // continuous 14-dword packet: two back-to-back frames
    do_reset();
    load(0, 14, 32'h600); drive();
    repeat (9) step();
    chk("t6_ov1",  ifc.out_valid, 1);
    chk("t6_tag1", ifc.out_data[31:0], 32'hE0000000);
    chk("t6_rdy",  ifc.src_ready[0], 1);
    repeat (7) step();
    chk("t6_ov2",  ifc.out_valid, 1);
    chk("t6_tag2", ifc.out_data[31:0], 32'hE8000000);
    chk("t6_d7",   ifc.out_data[255:224], 32'h60D);
    repeat (5) step();

    // random traffic, valid drops and back-pressure
    do_reset();
    drop_en = 1; afull_pct = 15;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) begin
        int s;
        s = int'($urandom_range(NS - 1));
        if (src_q[s].size() < 16) load(s, int'($urandom_range(12, 1)), $urandom);
      end
      step();
    end
    drop_en = 0; afull_pct = 0;
    repeat (60) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
